// File: rtl/rpn_pkg.sv
// rpn_pkg: opcodes, FSM states and opcode check shared by the RPN evaluator
package rpn_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    typedef enum logic [1:0] {IDLE, RD_B, RD_A, EXEC} state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_XOR;
    endfunction
endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational operator unit, result truncated to W bits
module rpn_alu import rpn_pkg::*; #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic [W-1:0] r_o
);
    // illegal opcodes never reach here; they fall through to XOR
    always_comb
        r_o = op_i == OP_ADD ? a_i + b_i :
              op_i == OP_SUB ? a_i - b_i :
              op_i == OP_MUL ? a_i * b_i :
              op_i == OP_AND ? a_i & b_i :
              op_i == OP_OR  ? a_i | b_i : a_i ^ b_i;
endmodule

// File: rtl/rpn_stack_eval.sv
// rpn_stack_eval: push/operator sequencer over an external registered-read stack RAM
module rpn_stack_eval import rpn_pkg::*; #(
    parameter int W  = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_valid,
    input  logic [W-1:0]  push_data,
    input  logic          op_valid,
    input  logic [2:0]    op_code,
    input  logic          err_clr,
    output logic          ready,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wren,
    output logic [W-1:0]  ram_wdata,
    input  logic [W-1:0]  ram_rdata,
    output logic [W-1:0]  tos,
    output logic [AW:0]   depth,
    output logic          err_underflow,
    output logic          err_overflow,
    output logic          err_opcode
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = (AW+1)'(1);
    localparam logic [AW:0] TWO   = (AW+1)'(2);

    state_e        state_q, state_d;
    logic [AW:0]   sp_q, sp_d;
    logic [W-1:0]  tos_q, tos_d, a_q, a_d, b_q, b_d, alu_r;
    logic [2:0]    op_q, op_d;
    logic          eu_q, eu_d, eo_q, eo_d, ec_q, ec_d;

    rpn_alu #(.W(W)) u_alu (.a_i(a_q), .b_i(b_q), .op_i(op_q), .r_o(alu_r));

    assign tos           = tos_q;
    assign depth         = sp_q;
    assign err_underflow = eu_q;
    assign err_overflow  = eo_q;
    assign err_opcode    = ec_q;

    // command decode, operator sequencing and RAM port drive; new errors override err_clr
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        tos_d     = tos_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        eu_d      = eu_q & ~err_clr;
        eo_d      = eo_q & ~err_clr;
        ec_d      = ec_q & ~err_clr;
        ram_wren  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        done      = 1'b0;
        ready     = state_q == IDLE;
        unique case (state_q)
            IDLE: begin
                if (push_valid) begin
                    if (sp_q == DEPTH) eo_d = 1'b1;
                    else begin
                        ram_wren  = 1'b1;
                        ram_addr  = AW'(sp_q);
                        ram_wdata = push_data;
                        sp_d      = sp_q + ONE;
                        tos_d     = push_data;
                    end
                end else if (op_valid) begin
                    if (!op_legal(op_code)) ec_d = 1'b1;
                    else if (sp_q < TWO) eu_d = 1'b1;
                    else begin
                        ram_addr = AW'(sp_q - ONE);
                        op_d     = op_code;
                        state_d  = RD_B;
                    end
                end
            end
            RD_B: begin
                b_d      = ram_rdata;
                ram_addr = AW'(sp_q - TWO);
                state_d  = RD_A;
            end
            RD_A: begin
                a_d      = ram_rdata;
                ram_addr = AW'(sp_q - TWO);
                state_d  = EXEC;
            end
            EXEC: begin
                ram_wren  = 1'b1;
                ram_addr  = AW'(sp_q - TWO);
                ram_wdata = alu_r;
                sp_d      = sp_q - ONE;
                tos_d     = alu_r;
                done      = 1'b1;
                state_d   = IDLE;
            end
        endcase
        if (!resetn) begin
            ram_wren  = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
            done      = 1'b0;
        end
    end

    // state registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            sp_q    <= '0;
            tos_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            eu_q    <= 1'b0;
            eo_q    <= 1'b0;
            ec_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            tos_q   <= tos_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            eu_q    <= eu_d;
            eo_q    <= eo_d;
            ec_q    <= ec_d;
        end
    end
endmodule

// File: tb/tb_rpn_stack_eval.sv
// tb_rpn_stack_eval: scoreboard bench for rpn_stack_eval with a 4-entry stack
module tb_rpn_stack_eval;
    import rpn_pkg::*;
    localparam int W  = 8;
    localparam int AW = 2;

    logic          clk = 1'b0, resetn = 1'b0, push_valid = 1'b0, op_valid = 1'b0, err_clr = 1'b0;
    logic [W-1:0]  push_data = '0;
    logic [2:0]    op_code = '0;
    logic          ready, done, ram_wren, err_underflow, err_overflow, err_opcode;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata, ram_rdata, tos;
    logic [AW:0]   depth;
    logic [W-1:0]  mem [4];

    typedef struct {logic [W-1:0] r; int c;} exp_t;
    exp_t sb[$];
    int cyc = 0, n_chk = 0, n_pass = 0, n_wr = 0, w;

    rpn_stack_eval #(.W(W), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .push_valid(push_valid), .push_data(push_data),
        .op_valid(op_valid), .op_code(op_code), .err_clr(err_clr), .ready(ready),
        .done(done), .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .tos(tos), .depth(depth), .err_underflow(err_underflow),
        .err_overflow(err_overflow), .err_opcode(err_opcode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ram_wren) n_wr++;
        if (done) begin
            if (sb.size() == 0) check("spurious done", 32'(done), 0);
            else begin
                e = sb.pop_front();
                check("result", 32'(ram_wdata), 32'(e.r));
                check("latency", cyc, e.c);
                check("done wren", 32'(ram_wren), 1);
            end
        end
    end

    task automatic do_reset;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic push(input logic [W-1:0] d);
        push_valid = 1'b1;
        push_data  = d;
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic op(input logic [2:0] c, input logic [W-1:0] r, input bit ok);
        op_valid = 1'b1;
        op_code  = c;
        if (ok) sb.push_back('{r, cyc + 3});
        @(posedge clk); #1;
        op_valid = 1'b0;
        if (ok) begin
            repeat (3) @(posedge clk);
            #1;
            check("op completed", sb.size(), 0);
        end
    endtask

    logic [W-1:0] ta [6] = '{8'd5, 8'd3, 8'd20, 8'hF0, 8'hF0, 8'hF0};
    logic [W-1:0] tb [6] = '{8'd7, 8'd10, 8'd13, 8'h3C, 8'h3C, 8'h3C};
    logic [2:0]   tc [6] = '{OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR};
    logic [W-1:0] tr [6] = '{8'd12, 8'hF9, 8'h04, 8'h30, 8'hFC, 8'hCC};

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("rst ready", 32'(ready), 1);
        check("rst depth", 32'(depth), 0);
        check("rst tos", 32'(tos), 0);
        check("rst errs", 32'({err_underflow, err_overflow, err_opcode}), 0);
        check("rst wren", 32'(ram_wren), 0);
        check("rst addr", 32'(ram_addr), 0);
        check("rst done", 32'(done), 0);

        for (int i = 0; i < 6; i++) begin
            do_reset;
            push(ta[i]);
            push(tb[i]);
            op(tc[i], tr[i], 1'b1);
            check("alu tos", 32'(tos), 32'(tr[i]));
            check("alu depth", 32'(depth), 1);
            check("alu mem0", 32'(mem[0]), 32'(tr[i]));
        end

        do_reset;
        push(8'd1);
        w = n_wr;
        op(OP_ADD, 8'd0, 1'b0);
        check("uf flag", 32'(err_underflow), 1);
        check("uf depth", 32'(depth), 1);
        check("uf tos", 32'(tos), 1);
        check("uf ready", 32'(ready), 1);
        check("uf no write", n_wr, w);
        op(3'b110, 8'd0, 1'b0);
        check("opc flag", 32'(err_opcode), 1);
        check("opc depth", 32'(depth), 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("clr errs", 32'({err_underflow, err_overflow, err_opcode}), 0);
        err_clr = 1'b1;
        op(3'b111, 8'd0, 1'b0);
        err_clr = 1'b0;
        check("clr+err", 32'({err_underflow, err_overflow, err_opcode}), 3'b001);

        do_reset;
        for (int i = 1; i <= 4; i++) push(W'(i));
        check("full depth", 32'(depth), 4);
        w = n_wr;
        push(8'd9);
        check("of flag", 32'(err_overflow), 1);
        check("of depth", 32'(depth), 4);
        check("of tos", 32'(tos), 4);
        check("of no write", n_wr, w);
        op(OP_ADD, 8'd7, 1'b1);
        check("full op depth", 32'(depth), 3);
        check("full op tos", 32'(tos), 7);

        do_reset;
        push(8'd1);
        push_valid = 1'b1;
        push_data  = 8'd2;
        op_valid   = 1'b1;
        op_code    = OP_ADD;
        sb.push_back('{8'd3, cyc + 4});
        @(posedge clk); #1;
        push_valid = 1'b0;
        check("prio depth", 32'(depth), 2);
        check("prio ready", 32'(ready), 1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("prio busy", 32'(ready), 0);
        repeat (3) @(posedge clk);
        #1;
        check("prio done", sb.size(), 0);
        check("prio tos", 32'(tos), 3);
        check("prio depth2", 32'(depth), 1);

        do_reset;
        push(8'd1);
        push(8'd2);
        w = n_wr;
        op_valid = 1'b1;
        op_code  = OP_ADD;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("abort ready", 32'(ready), 1);
        check("abort depth", 32'(depth), 0);
        check("abort tos", 32'(tos), 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort no write", n_wr, w);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
